// File: rtl/apb_bridge_if.sv
// Bus bundle between the CPU request port, the APB bridge and its APB slaves.
// The master modport is the bridge view; the slave modport is the CPU/slave-side view.
interface apb_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NSLAVES    = 4
);
  logic                          mem_valid;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic [3:0]                    mem_wstrb;
  logic [DATA_WIDTH-1:0]         mem_rdata;
  logic                          mem_ready;

  logic [ADDR_WIDTH-1:0]         paddr;
  logic [DATA_WIDTH-1:0]         pdata;
  logic                          pwrite;
  logic [3:0]                    pstb;
  logic [NSLAVES-1:0]            psel;
  logic                          penable;
  logic [NSLAVES*DATA_WIDTH-1:0] prdata_bus;
  logic [NSLAVES-1:0]            pready;
  logic [NSLAVES-1:0]            perr;
  logic                          APB_perr;

  modport master (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready,
    output paddr, pdata, pwrite, pstb, psel, penable,
    input  prdata_bus, pready, perr,
    output APB_perr
  );

  modport slave (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready,
    input  paddr, pdata, pwrite, pstb, psel, penable,
    output prdata_bus, pready, perr,
    input  APB_perr
  );
endinterface

// File: rtl/apb_bridge.sv
// apb_bridge: CPU request -> APB master with top-address-bit slave decode and error flagging.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles without pready.
module apb_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NSLAVES    = 4,
  parameter int SEL_BITS   = 4,
  parameter int TIMEOUT    = 16
) (
  input logic          pclk,
  input logic          presetn,
  apb_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_nx;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_nx;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_nx;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic [3:0]            pstb_q, pstb_nx;
  logic [NSLAVES-1:0]    psel_q, psel_nx;
  logic [NSLAVES-1:0]    dec_sel;
  logic                  pwrite_q, pwrite_nx;
  logic                  penable_q, penable_nx;
  logic                  ready_q, ready_nx;
  logic                  perr_q, perr_nx;
  logic [SEL_BITS-1:0]   idx;
  logic                  hit;
  logic                  sel_ready;
  logic                  sel_err;
  logic                  tmo_hit;

  assign idx = bus.mem_addr[ADDR_WIDTH-1 -: SEL_BITS];
  assign hit = int'(idx) < NSLAVES;

  always_comb begin
    dec_sel = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (int'(idx) == i) dec_sel[i] = 1'b1;
    end
  end

  // Only the currently selected slave's ready/error/data are ever looked at.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (psel_q[i]) sel_rdata = sel_rdata | bus.prdata_bus[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign sel_ready = |(bus.pready & psel_q);
  assign sel_err   = |(bus.perr & psel_q);

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt;

  // Held at zero outside ACCESS, so it is clear on SETUP entry.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      tmo_cnt <= '0;
    end else if (state == ACCESS) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = (state == ACCESS) && (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state     <= IDLE;
      paddr_q   <= '0;
      pdata_q   <= '0;
      rdata_q   <= '0;
      pstb_q    <= '0;
      psel_q    <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      ready_q   <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      paddr_q   <= paddr_nx;
      pdata_q   <= pdata_nx;
      rdata_q   <= rdata_nx;
      pstb_q    <= pstb_nx;
      psel_q    <= psel_nx;
      pwrite_q  <= pwrite_nx;
      penable_q <= penable_nx;
      ready_q   <= ready_nx;
      perr_q    <= perr_nx;
    end
  end

  // Next-state and next-output logic; mem_ready/APB_perr/mem_rdata are only set on RESP entry.
  always_comb begin
    state_nx   = state;
    paddr_nx   = paddr_q;
    pdata_nx   = pdata_q;
    pstb_nx    = pstb_q;
    pwrite_nx  = pwrite_q;
    psel_nx    = psel_q;
    penable_nx = penable_q;
    rdata_nx   = '0;
    ready_nx   = 1'b0;
    perr_nx    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.mem_valid) begin
          if (hit) begin
            paddr_nx   = bus.mem_addr;
            pdata_nx   = bus.mem_wdata;
            pstb_nx    = bus.mem_wstrb;
            pwrite_nx  = |bus.mem_wstrb;
            psel_nx    = dec_sel;
            penable_nx = 1'b0;
            state_nx   = SETUP;
          end else begin
            ready_nx = 1'b1;
            perr_nx  = 1'b1;
            state_nx = RESP;
          end
        end
      end
      SETUP: begin
        penable_nx = 1'b1;
        state_nx   = ACCESS;
      end
      ACCESS: begin
        if (sel_ready) begin
          psel_nx    = '0;
          penable_nx = 1'b0;
          ready_nx   = 1'b1;
          perr_nx    = sel_err;
          rdata_nx   = (!pwrite_q && !sel_err) ? sel_rdata : '0;
          state_nx   = RESP;
        end else if (tmo_hit) begin
          psel_nx    = '0;
          penable_nx = 1'b0;
          ready_nx   = 1'b1;
          perr_nx    = 1'b1;
          state_nx   = RESP;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.paddr     = paddr_q;
  assign bus.pdata     = pdata_q;
  assign bus.pstb      = pstb_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign bus.APB_perr  = perr_q;

endmodule

// File: tb/tb_apb_bridge.sv
// tb_apb_bridge: directed-vector bench for apb_bridge with a task-driven APB slave.
// Honours APB_TIMEOUT_EN the same way the design does.
module tb_apb_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;

  logic pclk = 1'b0;
  logic presetn;

  always #5 pclk = ~pclk;

  apb_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NSLAVES(NS)) bus ();

  apb_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NSLAVES(NS), .SEL_BITS(4), .TIMEOUT(16)
  ) dut (
    .pclk(pclk),
    .presetn(presetn),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic          done;
  int            lat;
  int            acc_cycles;
  int            perr_pulses;
  logic [NS-1:0] psel_seen;
  logic [NS-1:0] psel_resp;
  logic          penable_resp;
  logic          penable_setup;
  logic          pwrite_seen;
  logic [3:0]    pstb_seen;
  logic [31:0]   paddr_seen;
  logic [31:0]   pdata_seen;
  logic [31:0]   rdata_seen;
  logic          post_ready;
  logic          post_perr;
  logic          quiet_seen;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One CPU request; the target slave raises pready once it has seen more than wait_cycles ACCESS cycles
  // (wait_cycles < 0: never). Non-target slaves hold pready/perr high to prove they are ignored.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                               input int slave, input logic [31:0] sdata, input logic serr,
                               input int wait_cycles, input int budget);
    bit setup_seen = 0;
    done = 0; lat = 0; acc_cycles = 0; perr_pulses = 0;
    psel_seen = '0; psel_resp = '0; penable_resp = 1'b0; penable_setup = 1'b0;
    pwrite_seen = 1'b0; pstb_seen = '0; paddr_seen = '0; pdata_seen = '0; rdata_seen = '0;
    post_ready = 1'b0; post_perr = 1'b0;
    for (int i = 0; i < NS; i++) begin
      bus.prdata_bus[i*DW +: DW] = (i == slave) ? sdata : (32'hBAD0_0000 | 32'(i));
    end
    bus.pready = '1;
    bus.perr   = '1;
    if (slave >= 0 && slave < NS) begin
      bus.pready[slave] = 1'b0;
      bus.perr[slave]   = 1'b0;
    end
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
    bus.mem_valid = 1'b1;
    for (int c = 1; c <= budget && !done; c++) begin
      @(posedge pclk);
      @(negedge pclk);
      if (bus.APB_perr) perr_pulses++;
      psel_seen = psel_seen | bus.psel;
      if (bus.psel != '0 && !setup_seen) begin
        setup_seen    = 1;
        penable_setup = bus.penable;
        pwrite_seen   = bus.pwrite;
        pstb_seen     = bus.pstb;
        paddr_seen    = bus.paddr;
        pdata_seen    = bus.pdata;
      end
      if (bus.penable) begin
        acc_cycles++;
        if (wait_cycles >= 0 && acc_cycles > wait_cycles && slave >= 0 && slave < NS) begin
          bus.pready[slave] = 1'b1;
          bus.perr[slave]   = serr;
        end
      end
      if (bus.mem_ready) begin
        done          = 1'b1;
        lat           = c;
        rdata_seen    = bus.mem_rdata;
        psel_resp     = bus.psel;
        penable_resp  = bus.penable;
        bus.mem_valid = 1'b0;
        bus.pready    = '0;
        bus.perr      = '0;
      end
    end
    if (done) begin
      @(posedge pclk);
      @(negedge pclk);
      post_ready = bus.mem_ready;
      post_perr  = bus.APB_perr;
    end
  endtask

  initial begin
    presetn        = 1'b0;
    bus.mem_valid  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_wstrb  = '0;
    bus.prdata_bus = '0;
    bus.pready     = '0;
    bus.perr       = '0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    checkOutput("rst_psel",     64'(bus.psel),      64'(0));
    checkOutput("rst_penable",  64'(bus.penable),   64'(0));
    checkOutput("rst_pwrite",   64'(bus.pwrite),    64'(0));
    checkOutput("rst_pstb",     64'(bus.pstb),      64'(0));
    checkOutput("rst_paddr",    64'(bus.paddr),     64'(0));
    checkOutput("rst_pdata",    64'(bus.pdata),     64'(0));
    checkOutput("rst_ready",    64'(bus.mem_ready), 64'(0));
    checkOutput("rst_rdata",    64'(bus.mem_rdata), 64'(0));
    checkOutput("rst_apb_perr", 64'(bus.APB_perr),  64'(0));
    presetn = 1'b1;

    $display("[TB] read slave2, pready one cycle into ACCESS");
    applyStimulus(32'h2000_0000, 32'h0, 4'b0000, 2, 32'h0000_0001, 1'b0, 1, 50);
    checkOutput("rd2_done",    64'(done),          64'(1));
    checkOutput("rd2_latency", 64'(lat),           64'(4));
    checkOutput("rd2_psel",    64'(psel_seen),     64'(4'b0100));
    checkOutput("rd2_setup_en",64'(penable_setup), 64'(0));
    checkOutput("rd2_pwrite",  64'(pwrite_seen),   64'(0));
    checkOutput("rd2_pstb",    64'(pstb_seen),     64'(0));
    checkOutput("rd2_paddr",   64'(paddr_seen),    64'(32'h2000_0000));
    checkOutput("rd2_rdata",   64'(rdata_seen),    64'(32'h0000_0001));
    checkOutput("rd2_perr",    64'(perr_pulses),   64'(0));
    checkOutput("rd2_psel_rsp",64'(psel_resp),     64'(0));
    checkOutput("rd2_pen_rsp", 64'(penable_resp),  64'(0));
    checkOutput("rd2_pulse",   64'(post_ready),    64'(0));

    $display("[TB] write slave1 with partial strobes");
    applyStimulus(32'h1000_0004, 32'hA5A5_A5A5, 4'b0011, 1, 32'hDEAD_BEEF, 1'b0, 0, 50);
    checkOutput("wr1_done",    64'(done),        64'(1));
    checkOutput("wr1_latency", 64'(lat),         64'(3));
    checkOutput("wr1_psel",    64'(psel_seen),   64'(4'b0010));
    checkOutput("wr1_pwrite",  64'(pwrite_seen), 64'(1));
    checkOutput("wr1_pstb",    64'(pstb_seen),   64'(4'b0011));
    checkOutput("wr1_pdata",   64'(pdata_seen),  64'(32'hA5A5_A5A5));
    checkOutput("wr1_paddr",   64'(paddr_seen),  64'(32'h1000_0004));
    checkOutput("wr1_rdata",   64'(rdata_seen),  64'(0));
    checkOutput("wr1_perr",    64'(perr_pulses), 64'(0));

    $display("[TB] decode miss at index 4");
    applyStimulus(32'h4000_0000, 32'h0, 4'b0000, -1, 32'h0, 1'b0, 0, 50);
    checkOutput("miss_done",    64'(done),        64'(1));
    checkOutput("miss_latency", 64'(lat),         64'(1));
    checkOutput("miss_psel",    64'(psel_seen),   64'(0));
    checkOutput("miss_rdata",   64'(rdata_seen),  64'(0));
    checkOutput("miss_perr",    64'(perr_pulses), 64'(1));
    checkOutput("miss_pulse_p", 64'(post_perr),   64'(0));
    checkOutput("miss_pulse_r", 64'(post_ready),  64'(0));

    $display("[TB] slave0 reports an error");
    applyStimulus(32'h0000_0010, 32'h0, 4'b0000, 0, 32'h0000_1234, 1'b1, 0, 50);
    checkOutput("err0_latency", 64'(lat),         64'(3));
    checkOutput("err0_psel",    64'(psel_seen),   64'(4'b0001));
    checkOutput("err0_rdata",   64'(rdata_seen),  64'(0));
    checkOutput("err0_perr",    64'(perr_pulses), 64'(1));
    checkOutput("err0_pulse",   64'(post_perr),   64'(0));

    $display("[TB] read slave3 with three wait states");
    applyStimulus(32'h3000_0000, 32'h0, 4'b0000, 3, 32'hCAFE_F00D, 1'b0, 3, 50);
    checkOutput("rd3_latency", 64'(lat),         64'(6));
    checkOutput("rd3_psel",    64'(psel_seen),   64'(4'b1000));
    checkOutput("rd3_rdata",   64'(rdata_seen),  64'(32'hCAFE_F00D));
    checkOutput("rd3_perr",    64'(perr_pulses), 64'(0));

`ifdef APB_TIMEOUT_EN
    $display("[TB] slave2 never ready, timeout expected");
    applyStimulus(32'h2000_0000, 32'h0, 4'b0000, 2, 32'h7777_7777, 1'b0, -1, 60);
    checkOutput("tmo_done",    64'(done),        64'(1));
    checkOutput("tmo_access",  64'(acc_cycles),  64'(16));
    checkOutput("tmo_latency", 64'(lat),         64'(18));
    checkOutput("tmo_psel",    64'(psel_resp),   64'(0));
    checkOutput("tmo_rdata",   64'(rdata_seen),  64'(0));
    checkOutput("tmo_perr",    64'(perr_pulses), 64'(1));

    $display("[TB] pready in the last allowed ACCESS cycle");
    applyStimulus(32'h2000_0000, 32'h0, 4'b0000, 2, 32'h1357_9BDF, 1'b0, 15, 60);
    checkOutput("tmo_edge_latency", 64'(lat),         64'(18));
    checkOutput("tmo_edge_rdata",   64'(rdata_seen),  64'(32'h1357_9BDF));
    checkOutput("tmo_edge_perr",    64'(perr_pulses), 64'(0));

    applyStimulus(32'h2000_0000, 32'h0, 4'b0000, 2, 32'h0, 1'b0, -1, 5);
    checkOutput("stall_done", 64'(done), 64'(0));
`else
    $display("[TB] slave2 never ready, bridge must keep waiting");
    applyStimulus(32'h2000_0000, 32'h0, 4'b0000, 2, 32'h0, 1'b0, -1, 100);
    checkOutput("stall_done",    64'(done),        64'(0));
    checkOutput("stall_access",  64'(acc_cycles),  64'(99));
    checkOutput("stall_penable", 64'(bus.penable), 64'(1));
    checkOutput("stall_psel",    64'(bus.psel),    64'(4'b0100));
`endif

    $display("[TB] reset pulse during ACCESS");
    checkOutput("mid_in_access", 64'(bus.penable), 64'(1));
    presetn       = 1'b0;
    bus.mem_valid = 1'b0;
    bus.pready    = '0;
    bus.perr      = '0;
    @(posedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    checkOutput("mid_psel",    64'(bus.psel),      64'(0));
    checkOutput("mid_penable", 64'(bus.penable),   64'(0));
    checkOutput("mid_ready",   64'(bus.mem_ready), 64'(0));
    checkOutput("mid_perr",    64'(bus.APB_perr),  64'(0));
    checkOutput("mid_paddr",   64'(bus.paddr),     64'(0));
    quiet_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge pclk);
      @(negedge pclk);
      quiet_seen = quiet_seen | bus.mem_ready | bus.APB_perr | (bus.psel != '0);
    end
    checkOutput("mid_quiet", 64'(quiet_seen), 64'(0));

    applyStimulus(32'h1000_0008, 32'h0, 4'b0000, 1, 32'h0000_55AA, 1'b0, 0, 50);
    checkOutput("rec_done",    64'(done),        64'(1));
    checkOutput("rec_latency", 64'(lat),         64'(3));
    checkOutput("rec_rdata",   64'(rdata_seen),  64'(32'h0000_55AA));
    checkOutput("rec_perr",    64'(perr_pulses), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
